uart_serial_monitor: RTL and testbench

- Passive serial-line receiver that sits directly downstream of a CoreUARTapb TX pin, or on the shared RX2 net.
- Deserialises frames using the same 16x oversampling baud scheme as the UART core. Reports each byte with its parity and framing status through a valid/ready holding register.
- Used in subsystem benches and on-chip debug taps to check UART traffic independently of the APB side.

---
 rtl/uart_serial_monitor_if.sv | 29 ++
 rtl/uart_serial_monitor.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_serial_monitor.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_serial_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_serial_monitor_if                                           |
// | Purpose : Serial line, consumer handshake and status bundle for the        |
// |           UART serial monitor.                                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface uart_serial_monitor_if;
  logic        RX;
  logic        DATA_READY;
  logic        CLR_OVF;
  logic [7:0]  DATA_OUT;
  logic        DATA_VALID;
  logic        PARITY_ERR;
  logic        FRAMING_ERR;
  logic        OVERFLOW;
  logic [15:0] FRAME_COUNT;

  modport slave (
    input  RX, DATA_READY, CLR_OVF,
    output DATA_OUT, DATA_VALID, PARITY_ERR, FRAMING_ERR, OVERFLOW, FRAME_COUNT
  );

  modport master (
    output RX, DATA_READY, CLR_OVF,
    input  DATA_OUT, DATA_VALID, PARITY_ERR, FRAMING_ERR, OVERFLOW, FRAME_COUNT
  );
endinterface
`default_nettype wire

// File: rtl/uart_serial_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_serial_monitor                                              |
// | Purpose : Passive 16x-oversampling UART receiver reporting each byte with  |
// |           parity/framing status through a valid/ready holding register.   |
// | Option  : UART_MONITOR_MAJORITY_EN - 2-of-3 vote at tick counts 6/7/8.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module uart_serial_monitor #(
  parameter int BAUD_VALUE = 1,
  parameter int PRG_BIT8   = 1,
  parameter int PRG_PARITY = 0
) (
  input  logic                 PCLK,
  input  logic                 PRESETN,
  uart_serial_monitor_if.slave mon
);

  localparam logic [12:0] c_BAUD       = 13'(BAUD_VALUE);
  localparam logic [2:0]  c_LAST_BIT   = (PRG_BIT8 != 0) ? 3'd7 : 3'd6;
  localparam logic        c_HAS_PARITY = (PRG_PARITY != 0);
  localparam logic        c_ODD        = (PRG_PARITY == 2);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_START   = 3'd1;
  localparam logic [2:0] c_ST_DATA    = 3'd2;
  localparam logic [2:0] c_ST_PARITY  = 3'd3;
  localparam logic [2:0] c_ST_STOP    = 3'd4;
  localparam logic [2:0] c_ST_HOLDOFF = 3'd5;

  logic        r_rx_meta;
  logic        r_rx_s;
  logic        r_rx_d;
  logic        w_fall;
  logic [12:0] r_baud;
  logic        w_tick;
  logic [3:0]  r_tcnt;
  logic        w_sample_tick;
  logic        w_end_tick;
  logic        w_sample_val;
  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic        w_frame_start;
  logic        w_tcnt_clr;
  logic        w_shift_en;
  logic        w_bit_next;
  logic        w_par_en;
  logic        w_frame_done;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic [7:0]  w_data;
  logic        r_par_err;
  logic [7:0]  r_data_out;
  logic        r_valid;
  logic        r_par_out;
  logic        r_frm_out;
  logic        r_ovf;
  logic [15:0] r_frame_cnt;

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= mon.RX;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  assign w_fall = r_rx_d & ~r_rx_s;
  assign w_tick = (r_baud == c_BAUD);

  // Restarting the divisor on the start edge centres every sample in its bit.
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      r_baud <= 13'd0;
    end else if (w_frame_start || w_tick) begin
      r_baud <= 13'd0;
    end else begin
      r_baud <= r_baud + 13'd1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      r_tcnt <= 4'd0;
    end else if (w_tcnt_clr) begin
      r_tcnt <= 4'd0;
    end else if (w_tick) begin
      r_tcnt <= r_tcnt + 4'd1;
    end
  end

`ifdef UART_MONITOR_MAJORITY_EN
  localparam logic [3:0] c_SAMPLE_TCNT = 4'd8;
  logic r_s6;
  logic r_s7;

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      r_s6 <= 1'b1;
      r_s7 <= 1'b1;
    end else begin
      if (w_tick && (r_tcnt == 4'd6)) r_s6 <= r_rx_s;
      if (w_tick && (r_tcnt == 4'd7)) r_s7 <= r_rx_s;
    end
  end

  assign w_sample_val = (r_s6 & r_s7) | (r_s6 & r_rx_s) | (r_s7 & r_rx_s);
`else
  localparam logic [3:0] c_SAMPLE_TCNT = 4'd7;
  assign w_sample_val = r_rx_s;
`endif

  assign w_sample_tick = w_tick && (r_tcnt == c_SAMPLE_TCNT);
  assign w_end_tick    = w_tick && (r_tcnt == 4'd15);

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:    if (w_fall) w_next = c_ST_START;
      c_ST_START: begin
        if (w_sample_tick && w_sample_val) w_next = c_ST_IDLE;
        else if (w_end_tick)               w_next = c_ST_DATA;
      end
      c_ST_DATA: begin
        if (w_end_tick && (r_bitcnt == c_LAST_BIT))
          w_next = c_HAS_PARITY ? c_ST_PARITY : c_ST_STOP;
      end
      c_ST_PARITY:  if (w_end_tick) w_next = c_ST_STOP;
      // Completing at mid-stop leaves half a bit to resynchronise on the next start.
      c_ST_STOP:    if (w_sample_tick) w_next = w_sample_val ? c_ST_IDLE : c_ST_HOLDOFF;
      c_ST_HOLDOFF: if (r_rx_s) w_next = c_ST_IDLE;
      default:      w_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_frame_start = 1'b0;
    w_shift_en    = 1'b0;
    w_bit_next    = 1'b0;
    w_par_en      = 1'b0;
    w_frame_done  = 1'b0;
    w_tcnt_clr    = (w_next != r_state);
    case (r_state)
      c_ST_IDLE:   w_frame_start = w_fall;
      c_ST_DATA: begin
        w_shift_en = w_sample_tick;
        w_bit_next = w_end_tick;
      end
      c_ST_PARITY: w_par_en     = w_sample_tick;
      c_ST_STOP:   w_frame_done = w_sample_tick;
      default:     ;
    endcase
  end

  // 7-bit frames finish one shift short, leaving the byte in the upper bits.
  assign w_data = (PRG_BIT8 != 0) ? r_shift : {1'b0, r_shift[7:1]};

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      r_bitcnt  <= 3'd0;
      r_shift   <= 8'd0;
      r_par_err <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_bitcnt  <= 3'd0;
        r_par_err <= 1'b0;
      end else if (w_bit_next) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_shift_en) r_shift <= {w_sample_val, r_shift[7:1]};
      if (w_par_en)   r_par_err <= ((^w_data) ^ w_sample_val) != c_ODD;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      r_data_out  <= 8'd0;
      r_valid     <= 1'b0;
      r_par_out   <= 1'b0;
      r_frm_out   <= 1'b0;
      r_ovf       <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        if (!r_valid || mon.DATA_READY) begin
          r_data_out <= w_data;
          r_par_out  <= r_par_err;
          r_frm_out  <= ~w_sample_val;
          r_valid    <= 1'b1;
        end
      end else if (r_valid && mon.DATA_READY) begin
        r_valid <= 1'b0;
      end
      // A fresh overflow outranks a coincident clear.
      if (w_frame_done && r_valid && !mon.DATA_READY) begin
        r_ovf <= 1'b1;
      end else if (mon.CLR_OVF) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign mon.DATA_OUT    = r_data_out;
  assign mon.DATA_VALID  = r_valid;
  assign mon.PARITY_ERR  = r_par_out;
  assign mon.FRAMING_ERR = r_frm_out;
  assign mon.OVERFLOW    = r_ovf;
  assign mon.FRAME_COUNT = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_serial_monitor.sv
`default_nettype none
// Directed bench: DUT a is 8N1, DUT b is 8E1; both at BAUD_VALUE = 1 (32 PCLK per bit).
module tb_uart_serial_monitor;

  logic PCLK = 1'b0;
  logic PRESETN = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 PCLK = ~PCLK;

  uart_serial_monitor_if if_a ();
  uart_serial_monitor_if if_b ();

  uart_serial_monitor #(.BAUD_VALUE(1), .PRG_BIT8(1), .PRG_PARITY(0)) dut_a (
    .PCLK(PCLK), .PRESETN(PRESETN), .mon(if_a)
  );
  uart_serial_monitor #(.BAUD_VALUE(1), .PRG_BIT8(1), .PRG_PARITY(1)) dut_b (
    .PCLK(PCLK), .PRESETN(PRESETN), .mon(if_b)
  );

  // Record every accepted byte so single-cycle valid pulses are not missed.
  logic [7:0] cap_d_a [8];
  logic       cap_p_a [8];
  logic       cap_f_a [8];
  int         n_a = 0;
  logic [7:0] cap_d_b [8];
  logic       cap_p_b [8];
  int         n_b = 0;

  always @(negedge PCLK) begin
    if (if_a.DATA_VALID && if_a.DATA_READY) begin
      cap_d_a[n_a % 8] <= if_a.DATA_OUT;
      cap_p_a[n_a % 8] <= if_a.PARITY_ERR;
      cap_f_a[n_a % 8] <= if_a.FRAMING_ERR;
      n_a <= n_a + 1;
    end
    if (if_b.DATA_VALID && if_b.DATA_READY) begin
      cap_d_b[n_b % 8] <= if_b.DATA_OUT;
      cap_p_b[n_b % 8] <= if_b.PARITY_ERR;
      n_b <= n_b + 1;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    PRESETN = 1'b0;
    if_a.RX = 1'b1; if_a.DATA_READY = 1'b1; if_a.CLR_OVF = 1'b0;
    if_b.RX = 1'b1; if_b.DATA_READY = 1'b1; if_b.CLR_OVF = 1'b0;
    wait_cyc(4);
    PRESETN = 1'b1;
    wait_cyc(4);
  endtask

  // Drives n line bits LSB first, 32 PCLK each; sel 0 -> DUT a, 1 -> DUT b.
  task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) if_a.RX = v[i];
      else          if_b.RX = v[i];
      wait_cyc(32);
    end
  endtask

  task automatic test_reset();
    PRESETN = 1'b0;
    if_a.RX = 1'b1; if_a.DATA_READY = 1'b1; if_a.CLR_OVF = 1'b0;
    if_b.RX = 1'b1; if_b.DATA_READY = 1'b1; if_b.CLR_OVF = 1'b0;
    wait_cyc(4);
    @(negedge PCLK);
    total++; if (if_a.DATA_OUT !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", if_a.DATA_OUT); end
    total++; if (if_a.DATA_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_a.DATA_VALID); end
    total++; if (if_a.PARITY_ERR !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", if_a.PARITY_ERR); end
    total++; if (if_a.FRAMING_ERR !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", if_a.FRAMING_ERR); end
    total++; if (if_a.OVERFLOW !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", if_a.OVERFLOW); end
    total++; if (if_a.FRAME_COUNT !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h exp=0000", if_a.FRAME_COUNT); end
    PRESETN = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_basic();
    int base;
    do_reset();
    base = n_a;
    send_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
    wait_cyc(8);
    @(negedge PCLK);
    total++; if (n_a - base !== 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", n_a - base); end
    total++; if (cap_d_a[base % 8] !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", cap_d_a[base % 8]); end
    total++; if (cap_p_a[base % 8] !== 1'b0) begin bad++; $display("FAIL basic_perr got=%b exp=0", cap_p_a[base % 8]); end
    total++; if (cap_f_a[base % 8] !== 1'b0) begin bad++; $display("FAIL basic_ferr got=%b exp=0", cap_f_a[base % 8]); end
    total++; if (if_a.FRAME_COUNT !== 16'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", if_a.FRAME_COUNT); end
    total++; if (if_a.DATA_VALID !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b exp=0", if_a.DATA_VALID); end
  endtask

  task automatic test_parity();
    int base;
    do_reset();
    base = n_b;
    send_bits(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
    wait_cyc(8);
    @(negedge PCLK);
    total++; if (cap_d_b[base % 8] !== 8'h03) begin bad++; $display("FAIL par_bad_data got=%h exp=03", cap_d_b[base % 8]); end
    total++; if (cap_p_b[base % 8] !== 1'b1) begin bad++; $display("FAIL par_bad_perr got=%b exp=1", cap_p_b[base % 8]); end
    send_bits(1, {1'b1, 1'b0, 8'h03, 1'b0}, 11);
    wait_cyc(8);
    @(negedge PCLK);
    total++; if (n_b - base !== 2) begin bad++; $display("FAIL par_pulses got=%0d exp=2", n_b - base); end
    total++; if (cap_p_b[(base + 1) % 8] !== 1'b0) begin bad++; $display("FAIL par_good_perr got=%b exp=0", cap_p_b[(base + 1) % 8]); end
    total++; if (if_b.FRAME_COUNT !== 16'd2) begin bad++; $display("FAIL par_count got=%0d exp=2", if_b.FRAME_COUNT); end
  endtask

  task automatic test_break();
    int base;
    do_reset();
    base = n_a;
    send_bits(0, {1'b0, 8'h55, 1'b0}, 10);
    if_a.RX = 1'b0;
    wait_cyc(20 * 32);
    if_a.RX = 1'b1;
    wait_cyc(32);
    send_bits(0, {1'b1, 8'h3C, 1'b0}, 10);
    wait_cyc(8);
    @(negedge PCLK);
    total++; if (n_a - base !== 2) begin bad++; $display("FAIL brk_pulses got=%0d exp=2", n_a - base); end
    total++; if (cap_d_a[base % 8] !== 8'h55) begin bad++; $display("FAIL brk_first_data got=%h exp=55", cap_d_a[base % 8]); end
    total++; if (cap_f_a[base % 8] !== 1'b1) begin bad++; $display("FAIL brk_first_ferr got=%b exp=1", cap_f_a[base % 8]); end
    total++; if (cap_d_a[(base + 1) % 8] !== 8'h3C) begin bad++; $display("FAIL brk_second_data got=%h exp=3c", cap_d_a[(base + 1) % 8]); end
    total++; if (cap_f_a[(base + 1) % 8] !== 1'b0) begin bad++; $display("FAIL brk_second_ferr got=%b exp=0", cap_f_a[(base + 1) % 8]); end
    total++; if (if_a.FRAME_COUNT !== 16'd2) begin bad++; $display("FAIL brk_count got=%0d exp=2", if_a.FRAME_COUNT); end
  endtask

  task automatic test_false_start();
    int base;
    do_reset();
    base = n_a;
    if_a.RX = 1'b0;
    wait_cyc(6);
    if_a.RX = 1'b1;
    wait_cyc(400);
    @(negedge PCLK);
    total++; if (n_a - base !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d exp=0", n_a - base); end
    total++; if (if_a.FRAME_COUNT !== 16'd0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", if_a.FRAME_COUNT); end
`ifdef UART_MONITOR_MAJORITY_EN
    base = n_a;
    send_bits(0, {8'hFF, 1'b0}, 4);
    if_a.RX = 1'b1; wait_cyc(16);
    if_a.RX = 1'b0; wait_cyc(2);
    if_a.RX = 1'b1; wait_cyc(14);
    send_bits(0, 16'h000F, 5);
    wait_cyc(8);
    @(negedge PCLK);
    total++; if (cap_d_a[base % 8] !== 8'hFF) begin bad++; $display("FAIL vote_data got=%h exp=ff", cap_d_a[base % 8]); end
`endif
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    base = n_a;
    if_a.DATA_READY = 1'b0;
    send_bits(0, {1'b1, 8'h11, 1'b0}, 10);
    send_bits(0, {1'b1, 8'h22, 1'b0}, 10);
    wait_cyc(8);
    @(negedge PCLK);
    total++; if (if_a.DATA_OUT !== 8'h11) begin bad++; $display("FAIL ovf_data got=%h exp=11", if_a.DATA_OUT); end
    total++; if (if_a.DATA_VALID !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b exp=1", if_a.DATA_VALID); end
    total++; if (if_a.OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", if_a.OVERFLOW); end
    total++; if (if_a.FRAME_COUNT !== 16'd2) begin bad++; $display("FAIL ovf_count got=%0d exp=2", if_a.FRAME_COUNT); end
    wait_cyc(1);
    if_a.CLR_OVF = 1'b1;
    wait_cyc(1);
    if_a.CLR_OVF = 1'b0;
    wait_cyc(1);
    @(negedge PCLK);
    total++; if (if_a.OVERFLOW !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", if_a.OVERFLOW); end
    total++; if (if_a.DATA_VALID !== 1'b1) begin bad++; $display("FAIL ovf_still_held got=%b exp=1", if_a.DATA_VALID); end
    wait_cyc(1);
    if_a.DATA_READY = 1'b1;
    wait_cyc(2);
    @(negedge PCLK);
    total++; if (if_a.DATA_VALID !== 1'b0) begin bad++; $display("FAIL ovf_drain_valid got=%b exp=0", if_a.DATA_VALID); end
    total++; if (n_a - base !== 1 || cap_d_a[base % 8] !== 8'h11) begin
      bad++; $display("FAIL ovf_drain_data got=%h n=%0d exp=11 n=1", cap_d_a[base % 8], n_a - base);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    do_reset();
    base = n_a;
    send_bits(0, {8'h7E, 1'b0}, 5);
    if_a.RX = 1'b1;
    wait_cyc(10);
    PRESETN = 1'b0;
    wait_cyc(4);
    PRESETN = 1'b1;
    wait_cyc(64);
    send_bits(0, {1'b1, 8'h81, 1'b0}, 10);
    wait_cyc(8);
    @(negedge PCLK);
    total++; if (n_a - base !== 1) begin bad++; $display("FAIL rst_pulses got=%0d exp=1", n_a - base); end
    total++; if (cap_d_a[base % 8] !== 8'h81) begin bad++; $display("FAIL rst_data got=%h exp=81", cap_d_a[base % 8]); end
    total++; if (cap_p_a[base % 8] !== 1'b0 || cap_f_a[base % 8] !== 1'b0) begin
      bad++; $display("FAIL rst_flags got=%b%b exp=00", cap_p_a[base % 8], cap_f_a[base % 8]);
    end
    total++; if (if_a.FRAME_COUNT !== 16'd1) begin bad++; $display("FAIL rst_count got=%0d exp=1", if_a.FRAME_COUNT); end
    total++; if (if_a.OVERFLOW !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", if_a.OVERFLOW); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_false_start();
    test_overflow();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
